// File: rtl/acc_64bit_ctrl_if.sv
// Bus bundle for the 64-bit accumulator controller: upstream word channel,
// external ripple-carry adder hookup, and downstream result channel.
interface acc_64bit_ctrl_if;
  // Valid/ready rule for both channels: a transfer happens on a rising edge
  // where valid and ready are both 1. A source raises valid without waiting
  // for ready and holds valid and payload until that edge. A sink may change
  // ready at any time. A valid without ready transfers nothing.
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_sub;
  logic        in_clr;
  logic        in_last;

  logic [63:0] add_a;
  logic [63:0] add_b;
  logic        add_cin;
  logic [63:0] add_sum;
  logic        add_cout;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_ovf;

  modport slave (
    input  in_valid, in_data, in_sub, in_clr, in_last,
    input  add_sum, add_cout,
    input  out_ready,
    output in_ready,
    output add_a, add_b, add_cin,
    output out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_data, in_sub, in_clr, in_last,
    output add_sum, add_cout,
    output out_ready,
    input  in_ready,
    input  add_a, add_b, add_cin,
    input  out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/acc_64bit_ctrl.sv
// Accumulator controller that drives an external 64-bit ripple-carry adder,
// waits a fixed number of settle cycles, then captures sum and overflow.
module acc_64bit_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  acc_64bit_ctrl_if.slave  bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = SETTLE_CYCLES[3:0];

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [63:0] acc;
  logic        ovf;
  logic [63:0] add_a_r;
  logic [63:0] add_b_r;
  logic        add_cin_r;
  logic        sub_l;
  logic        clr_l;
  logic        last_l;

  logic        in_ready_c;
  logic        out_valid_c;
  logic        accept;
  logic        capture;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // Counter of 1 means this edge is the SETTLE_CYCLES-th since accept.
        if (cnt <= 4'd1) begin
          capture   = 1'b1;
          state_nxt = last_l ? DONE : IDLE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Adder operands are launched at accept and held untouched until the next
  // accept, so the ripple chain sees constant inputs through the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_r   <= 64'd0;
      add_b_r   <= 64'd0;
      add_cin_r <= 1'b0;
      sub_l     <= 1'b0;
      clr_l     <= 1'b0;
      last_l    <= 1'b0;
    end else if (accept) begin
      add_a_r   <= bus.in_clr ? 64'd0 : acc;
      add_b_r   <= bus.in_sub ? ~bus.in_data : bus.in_data;
      add_cin_r <= bus.in_sub;
      sub_l     <= bus.in_sub;
      clr_l     <= bus.in_clr;
      last_l    <= bus.in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= SETTLE_INIT;
    end else if (state == SETTLE && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Subtraction is a + ~b + 1, so a missing carry-out signals a borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 64'd0;
      ovf <= 1'b0;
    end else if (capture) begin
      acc <= bus.add_sum;
      ovf <= (clr_l ? 1'b0 : ovf) | (sub_l ? ~bus.add_cout : bus.add_cout);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = acc;
  assign bus.out_ovf   = ovf;
  assign bus.add_a     = add_a_r;
  assign bus.add_b     = add_b_r;
  assign bus.add_cin   = add_cin_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_acc_64bit_ctrl.sv
// Self-checking bench for acc_64bit_ctrl: directed scenarios plus randomized
// sequences checked against an arithmetic model of the accumulator.
module tb_acc_64bit_ctrl;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         accept_cyc = 0;

  logic [63:0] m_acc = 64'd0;
  logic        m_ovf = 1'b0;
  logic [64:0] exp_q[$];

  acc_64bit_ctrl_if bus();

  acc_64bit_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock/reset block and external adder.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {64'd0, bus.add_cin};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: plain unsigned arithmetic on the running accumulator.
  task automatic model_word(input logic [63:0] d, input bit sub, input bit clr, input bit last);
    logic [63:0] base;
    logic [64:0] wide;
    base = clr ? 64'd0 : m_acc;
    if (clr) m_ovf = 1'b0;
    if (sub) begin
      if (d > base) m_ovf = 1'b1;
      m_acc = base - d;
    end else begin
      wide = {1'b0, base} + {1'b0, d};
      if (wide[64]) m_ovf = 1'b1;
      m_acc = wide[63:0];
    end
    if (last) exp_q.push_back({m_ovf, m_acc});
  endtask

  task automatic model_reset();
    m_acc = 64'd0;
    m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // Driver: presents one word, waits (bounded) for acceptance, checks operands.
  task automatic send_word(input logic [63:0] d, input bit sub, input bit clr,
                           input bit last, input bit hold);
    int waited;
    logic [63:0] ea;
    logic [63:0] eb;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_sub   = sub;
    bus.in_clr   = clr;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, waited);
      bus.in_valid = 1'b0;
      return;
    end
    accept_cyc = cyc;
    ea = clr ? 64'd0 : m_acc;
    eb = sub ? ~d : d;
    @(posedge clk);
    model_word(d, sub, clr, last);
    if (!hold) begin
      #1;
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (bus.add_a !== ea || bus.add_b !== eb || bus.add_cin !== sub) begin
      n_fail++;
      $display("FAIL operands: a=%h b=%h cin=%0b, required a=%h b=%h cin=%0b",
               bus.add_a, bus.add_b, bus.add_cin, ea, eb, sub);
    end
  endtask

  // Waits for a result, checks it against the scoreboard, then releases it.
  task automatic get_result(input bit chk_lat, input int delay);
    int lat;
    logic [64:0] exp;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_timeout: out_valid=%0b, required 1", bus.out_valid);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (chk_lat) begin
      n_tests++;
      if (lat != S) begin
        n_fail++;
        $display("FAIL latency: %0d edges after accept, required %0d", lat, S);
      end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
    n_tests++;
    if ({bus.out_ovf, bus.out_data} !== exp) begin
      n_fail++;
      $display("FAIL result: data=%h ovf=%0b, required data=%h ovf=%0b",
               bus.out_data, bus.out_ovf, exp[63:0], exp[64]);
    end
    repeat (delay) @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: out_valid=%0b in_ready=%0b, required 0 and 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 ||
        bus.out_ovf !== 1'b0 || bus.add_a !== 64'd0 || bus.add_b !== 64'd0 || bus.add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rdy=%0b vld=%0b data=%h ovf=%0b a=%h b=%h cin=%0b, required 1 0 0 0 0 0 0",
               tag, bus.in_ready, bus.out_valid, bus.out_data, bus.out_ovf, bus.add_a, bus.add_b, bus.add_cin);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.in_sub = 1'b0;
    bus.in_clr = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    send_word(64'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(64'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    get_result(1'b1, 0);
  endtask

  task automatic test_carry();
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(64'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    get_result(1'b1, 0);
  endtask

  task automatic test_borrow();
    send_word(64'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(64'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    get_result(1'b1, 0);
  endtask

  task automatic test_ovf_clear();
    send_word(64'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    get_result(1'b1, 0);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [64:0] exp;
    send_word({$urandom(), $urandom()}, 1'b0, 1'b1, 1'b1, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
    bus.in_data  = {$urandom(), $urandom()};
    bus.in_clr   = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.out_ovf, bus.out_data} !== exp) begin
        n_fail++;
        $display("FAIL stall_%0d: vld=%0b rdy=%0b data=%h ovf=%0b, required 1 0 %h %0b",
                 i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_ovf, exp[63:0], exp[64]);
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: vld=%0b rdy=%0b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  // Accumulation continues from the previous result when clr is not set.
  task automatic test_persist();
    send_word({32'd0, $urandom()}, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word({32'd0, $urandom()}, 1'b1, 1'b0, 1'b1, 1'b0);
    get_result(1'b1, 1);
  endtask

  task automatic test_back_to_back();
    int prev;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      send_word({$urandom(), $urandom()}, i[0], (i == 0), (i == 4), (i != 4));
      if (i > 0) begin
        n_tests++;
        if (accept_cyc - prev != S + 1) begin
          n_fail++;
          $display("FAIL throughput_%0d: spacing %0d cycles, required %0d", i, accept_cyc - prev, S + 1);
        end
      end
      prev = accept_cyc;
    end
    get_result(1'b1, 0);
  endtask

  task automatic test_reset_mid();
    send_word(64'd123, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_settle");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(64'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    get_result(1'b1, 0);
  endtask

  task automatic test_random();
    int len;
    logic [63:0] d;
    for (int s = 0; s < 25; s++) begin
      len = $urandom_range(1, 4);
      for (int w = 0; w < len; w++) begin
        case ($urandom_range(0, 3))
          0: d = 64'hFFFF_FFFF_FFFF_FFFF - {56'd0, 8'($urandom())};
          1: d = {56'd0, 8'($urandom())};
          default: d = {$urandom(), $urandom()};
        endcase
        send_word(d, 1'($urandom_range(0, 1)), (w == 0) && ($urandom_range(0, 2) != 0),
                  (w == len - 1), 1'b0);
      end
      get_result(1'b0, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_borrow();
    test_ovf_clear();
    test_backpressure();
    test_persist();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_64bit_ctrl.md
ACC_64BIT_CTRL -- requirements
Module: acc_64bit_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, number of whole cycles the external 64-bit ripple-carry adder is given to settle before its result is captured; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  upstream word available.
REQ-005 in_ready  out  1  block can accept a word this cycle.
REQ-006 in_data  in  64  operand word.
REQ-007 in_sub  in  1  1 = subtract in_data from accumulator, 0 = add.
REQ-008 in_clr  in  1  1 = start new accumulation; accumulator treated as 0 and overflow flag cleared for this word.
REQ-009 in_last  in  1  word is final of a sequence; result is presented after it.
REQ-010 add_a  out  64  adder operand A (registered).
REQ-011 add_b  out  64  adder operand B (registered).
REQ-012 add_cin  out  1  adder carry-in (registered).
REQ-013 add_sum  in  64  adder sum result.
REQ-014 add_cout  in  1  adder carry-out.
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  downstream accepts result.
REQ-017 out_data  out  64  accumulated result; equals accumulator register.
REQ-018 out_ovf  out  1  sticky unsigned overflow/borrow flag for current sequence.

Function
REQ-019 The block SHALL implement FSM states IDLE, SETTLE, DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored.
REQ-021 On accept: add_a <= (in_clr ? 0 : acc); add_b <= (in_sub ? ~in_data : in_data); add_cin <= in_sub; in_sub, in_clr, in_last latched; settle counter <= SETTLE_CYCLES; state <= SETTLE.
REQ-022 In SETTLE the counter SHALL decrement each cycle; on the edge where it would reach 0 (exactly SETTLE_CYCLES edges after accept) acc <= add_sum.
REQ-023 At that capture edge, ovf <= (latched clr ? 0 : ovf) | (latched sub ? ~add_cout : add_cout).
REQ-024 At capture, state SHALL go to DONE if latched last=1, else IDLE.
REQ-025 add_a/add_b/add_cin SHALL hold stable from accept edge through capture edge.
REQ-026 In DONE out_valid=1; out_data and out_ovf SHALL hold stable until a rising edge with out_ready=1, then state <= IDLE and out_valid <= 0.
REQ-027 acc and ovf SHALL persist across sequences; only in_clr or reset clears them.
REQ-028 Throughput: one word per SETTLE_CYCLES+1 cycles when not last and in_valid held high.
REQ-029 All arithmetic is modulo 2^64; bits beyond 64 SHALL be discarded except as reflected in ovf.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, in_ready=1, out_valid=0, acc=0, out_data=0, ovf=0, add_a=0, add_b=0, add_cin=0, counter=0.
REQ-031 Reset during SETTLE or DONE SHALL abort the operation; the in-flight word and pending result are discarded.
REQ-032 After rst_n deasserts, the first accept SHALL occur no earlier than the first rising edge with rst_n=1.

Verification (SETTLE_CYCLES=2)
REQ-033 clr+add 5, then add 7 last -> out_valid=1 two edges after second accept, out_data=12, out_ovf=0.
REQ-034 clr+add 0xFFFF_FFFF_FFFF_FFFF, add 1 last -> out_data=0, out_ovf=1.
REQ-035 clr+add 3, sub 5 last -> out_data=0xFFFF_FFFF_FFFF_FFFE, out_ovf=1 (borrow).
REQ-036 Result pending with out_ready=0 for 4 cycles while in_valid=1 -> out_valid, out_data, out_ovf stable, in_ready=0, no word accepted; out_ready=1 -> IDLE next cycle.
REQ-037 rst_n pulsed low mid-SETTLE -> all outputs per REQ-030 immediately; next clr+add 9 last -> out_data=9, out_ovf=0.
REQ-038 After sequence ending with out_ovf=1, clr+add 9 last -> out_data=9, out_ovf=0.
